// File: rtl/pixel_frame_collector.sv
// Sensor readout collector: frame-aligned word capture, FIFO buffering and a pixel serializer.
// Optional build macro SATURATION_COUNT_EN adds SAT_COUNT (all-ones pixels per frame).
module pixel_frame_collector #(
    parameter int PIXEL_BITS   = 8,
    parameter int BUS_WIDTH    = 2,
    parameter int ARRAY_WIDTH  = 4,
    parameter int ARRAY_HEIGHT = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int FRAME_CNT_W  = 8
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            START,
    input  logic [FRAME_CNT_W-1:0]          NUM_FRAMES,
    input  logic                            IN_VALID,
    input  logic [BUS_WIDTH*PIXEL_BITS-1:0] IN_DATA,
    input  logic                            IN_FRAME_FINISHED,
    input  logic                            OUT_READY,
    output logic                            OUT_VALID,
    output logic [PIXEL_BITS-1:0]           OUT_DATA,
    output logic                            OUT_SOF,
    output logic                            OUT_EOL,
    output logic                            OUT_EOF,
    output logic                            BUSY,
    output logic                            ALL_DONE,
    output logic                            OVERFLOW,
    output logic [FRAME_CNT_W-1:0]          FRAMES_DONE
`ifdef SATURATION_COUNT_EN
    ,
    output logic [$clog2(ARRAY_WIDTH*ARRAY_HEIGHT+1)-1:0] SAT_COUNT
`endif
);
    localparam int WPR    = ARRAY_WIDTH / BUS_WIDTH;
    localparam int WPF    = ARRAY_WIDTH * ARRAY_HEIGHT / BUS_WIDTH;
    localparam int WCNT_W = (WPF > 1) ? $clog2(WPF) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int PIX_W  = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WPF - 1);
    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(BUS_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic                     ff_prev_q;
    logic [FRAME_CNT_W-1:0]   frames_q, frames_d;
    logic [FRAME_CNT_W-1:0]   nframes_q, nframes_d;
    logic                     ovf_q, ovf_d;
    logic [WCNT_W-1:0]        wcnt_q, wcnt_d;
    logic [PTR_W:0]           wr_ptr_q, rd_ptr_q;
    logic [PIX_W-1:0]         pix_idx_q;

    logic [BUS_WIDTH*PIXEL_BITS-1:0] mem_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]           mem_sof_q, mem_eol_q, mem_eof_q;

    logic                     full, empty, hs, last_pix, pop, eof_hs;
    logic                     capt_vld, wr_en, drop, ff_edge, last_word;
    logic                     tag_sof, tag_eol, tag_eof;
    logic [31:0]              col_pos;
    logic [PTR_W-1:0]         wr_idx, rd_idx, prev_idx;
    logic [BUS_WIDTH*PIXEL_BITS-1:0] head_word;
    logic [PIXEL_BITS-1:0]    pix_data;

    assign wr_idx    = wr_ptr_q[PTR_W-1:0];
    assign rd_idx    = rd_ptr_q[PTR_W-1:0];
    assign prev_idx  = wr_idx - PTR_W'(1);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);
    assign hs        = OUT_VALID & OUT_READY;
    assign last_pix  = (pix_idx_q == LAST_PIX);
    assign pop       = hs & last_pix;
    assign eof_hs    = hs & OUT_EOF;
    assign ff_edge   = IN_FRAME_FINISHED & ~ff_prev_q;
    assign last_word = (wcnt_q == LAST_WORD);
    assign capt_vld  = (state_q == S_CAPTURE) & IN_VALID;
    // A pop in the same cycle frees a slot, so a write into a full FIFO is still accepted.
    assign wr_en     = capt_vld & (~full | pop);
    assign drop      = capt_vld & full & ~pop;

    assign col_pos   = 32'(wcnt_q) % 32'(WPR);
    assign tag_sof   = (wcnt_q == '0);
    assign tag_eol   = (col_pos == 32'(WPR - 1));
    assign tag_eof   = last_word;

    always_comb begin
        state_d   = state_q;
        frames_d  = frames_q;
        nframes_d = nframes_q;
        ovf_d     = ovf_q;
        wcnt_d    = wcnt_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (START) begin
                state_d   = S_SYNC;
                frames_d  = '0;
                ovf_d     = 1'b0;
                nframes_d = NUM_FRAMES;
            end
            S_SYNC: if (ff_edge) begin
                state_d = S_CAPTURE;
                wcnt_d  = '0;
            end
            S_CAPTURE: if (IN_VALID) begin
                wcnt_d = last_word ? '0 : wcnt_q + WCNT_W'(1);
                if (last_word) state_d = S_DRAIN;
            end
            S_DRAIN: if (eof_hs) begin
                state_d = ((nframes_q != '0) && ((frames_q + FRAME_CNT_W'(1)) == nframes_q))
                          ? S_DONE : S_SYNC;
            end
            default: state_d = S_IDLE;
        endcase
        if (drop)   ovf_d    = 1'b1;
        if (eof_hs) frames_d = frames_q + FRAME_CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            ff_prev_q <= 1'b1;
            frames_q  <= '0;
            nframes_q <= '0;
            ovf_q     <= 1'b0;
            wcnt_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pix_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ff_prev_q <= IN_FRAME_FINISHED;
            frames_q  <= frames_d;
            nframes_q <= nframes_d;
            ovf_q     <= ovf_d;
            wcnt_q    <= wcnt_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
            if (hs)    pix_idx_q <= last_pix ? '0 : pix_idx_q + PIX_W'(1);
        end
    end

    // A dropped row/frame-closing word hands its EOL/EOF tags to the newest stored word,
    // so the frame still terminates downstream and DRAIN can exit.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_data_q[wr_idx] <= IN_DATA;
            mem_sof_q[wr_idx]  <= tag_sof;
            mem_eol_q[wr_idx]  <= tag_eol;
            mem_eof_q[wr_idx]  <= tag_eof;
        end else if (drop) begin
            mem_eol_q[prev_idx] <= mem_eol_q[prev_idx] | tag_eol;
            mem_eof_q[prev_idx] <= mem_eof_q[prev_idx] | tag_eof;
        end
    end

    assign head_word   = mem_data_q[rd_idx];
    assign pix_data    = head_word[pix_idx_q*PIXEL_BITS +: PIXEL_BITS];
    assign OUT_VALID   = ~empty;
    assign OUT_DATA    = OUT_VALID ? pix_data : '0;
    assign OUT_SOF     = OUT_VALID & mem_sof_q[rd_idx] & (pix_idx_q == '0);
    assign OUT_EOL     = OUT_VALID & mem_eol_q[rd_idx] & last_pix;
    assign OUT_EOF     = OUT_VALID & mem_eof_q[rd_idx] & last_pix;
    assign BUSY        = (state_q == S_SYNC) | (state_q == S_CAPTURE) | (state_q == S_DRAIN);
    assign ALL_DONE    = (state_q == S_DONE);
    assign OVERFLOW    = ovf_q;
    assign FRAMES_DONE = frames_q;

`ifdef SATURATION_COUNT_EN
    localparam int SAT_W = $clog2(ARRAY_WIDTH*ARRAY_HEIGHT+1);
    logic [SAT_W-1:0] sat_q;

    // Restarts on the SOF pixel itself, then holds past EOF until the next SOF.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sat_q <= '0;
        end else if (hs) begin
            if (OUT_SOF)        sat_q <= (&pix_data) ? SAT_W'(1) : '0;
            else if (&pix_data) sat_q <= sat_q + SAT_W'(1);
        end
    end

    assign SAT_COUNT = sat_q;
`endif

endmodule

// File: tb/tb_pixel_frame_collector.sv
// Directed bench: a default-depth instance plus a 4-deep instance that shares its stimulus.
module tb_pixel_frame_collector;
    logic        clk = 1'b0;
    logic        rst, start, vld, ff, rdy;
    logic [7:0]  nf;
    logic [15:0] din;
    logic        ov, osof, oeol, oeof, busy, alld, ovf;
    logic [7:0]  od, fd;
    logic        ov4, osof4, oeol4, oeof4, busy4, alld4, ovf4;
    logic [7:0]  od4, fd4;
`ifdef SATURATION_COUNT_EN
    logic [4:0]  sat, sat4;
`endif

    int n_cmp = 0;
    int n_mis = 0;
    int stall_viol = 0;
    bit stall_pend = 1'b0;
    logic [10:0] stall_d;
    bit tog = 1'b0;
    logic [10:0] q[$];
    logic [10:0] q4[$];
    bit ovf_hist[8];
    bit ovf4_hist[8];
    bit first_vld, first_sof;

    always #5 clk = ~clk;

    pixel_frame_collector dut (
        .CLK(clk), .RESET(rst), .START(start), .NUM_FRAMES(nf), .IN_VALID(vld),
        .IN_DATA(din), .IN_FRAME_FINISHED(ff), .OUT_READY(rdy), .OUT_VALID(ov),
        .OUT_DATA(od), .OUT_SOF(osof), .OUT_EOL(oeol), .OUT_EOF(oeof), .BUSY(busy),
        .ALL_DONE(alld), .OVERFLOW(ovf), .FRAMES_DONE(fd)
`ifdef SATURATION_COUNT_EN
        , .SAT_COUNT(sat)
`endif
    );

    pixel_frame_collector #(.FIFO_DEPTH(4)) dut4 (
        .CLK(clk), .RESET(rst), .START(start), .NUM_FRAMES(nf), .IN_VALID(vld),
        .IN_DATA(din), .IN_FRAME_FINISHED(ff), .OUT_READY(rdy), .OUT_VALID(ov4),
        .OUT_DATA(od4), .OUT_SOF(osof4), .OUT_EOL(oeol4), .OUT_EOF(oeof4), .BUSY(busy4),
        .ALL_DONE(alld4), .OVERFLOW(ovf4), .FRAMES_DONE(fd4)
`ifdef SATURATION_COUNT_EN
        , .SAT_COUNT(sat4)
`endif
    );

    // Record every pixel handshake and watch that stalled outputs do not move.
    always @(negedge clk) begin
        if (!rst) begin
            if (ov && rdy)   q.push_back({oeof, oeol, osof, od});
            if (ov4 && rdy)  q4.push_back({oeof4, oeol4, osof4, od4});
            if (stall_pend && !(ov && ({oeof, oeol, osof, od} == stall_d)))
                stall_viol <= stall_viol + 1;
            stall_pend <= ov && !rdy;
            stall_d    <= {oeof, oeol, osof, od};
        end else begin
            stall_pend <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (tog) rdy = ~rdy;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input bit satpat);
        ff = 1'b1;
        tick();
        ff = 1'b0;
        for (int k = 0; k < 8; k++) begin
            vld = 1'b1;
            din = {8'(2*k+1), 8'(2*k)};
            if (satpat && (k == 1 || k == 2)) din = 16'hFFFF;
            if (satpat && k == 5)             din = {8'(2*k+1), 8'hFF};
            tick();
            if (k == 0) begin
                first_vld = ov;
                first_sof = osof;
            end
            ovf_hist[k]  = ovf;
            ovf4_hist[k] = ovf4;
        end
        vld = 1'b0;
    endtask

    task automatic wait_both_done(input string tag);
        int i;
        for (i = 0; i < 200 && !(alld && alld4); i++) tick();
        chk({tag, "_done_in_time"}, 32'(alld && alld4), 32'd1);
    endtask

    // mode 0: normal 4x4 frames; 1: 4-deep run at full rate; 2: 4-deep run fully stalled
    task automatic check_q(input string tag, input bit use4, input int n, input int mode);
        int sz;
        logic [10:0] got, e;
        sz = use4 ? q4.size() : q.size();
        chk({tag, "_count"}, 32'(sz), 32'(n));
        for (int i = 0; i < n && i < sz; i++) begin
            got = use4 ? q4[i] : q[i];
            case (mode)
                1:       e = {i == 13, (i % 4 == 3) || (i == 13), i == 0, 8'(i)};
                2:       e = {i == 7, i % 4 == 3, i == 0, 8'(i)};
                default: e = {i % 16 == 15, i % 4 == 3, i % 16 == 0, 8'(i % 16)};
            endcase
            chk($sformatf("%s_px%0d", tag, i), 32'(got), 32'(e));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; nf = 8'd0; vld = 1'b0; din = 16'h0; ff = 1'b0; rdy = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", 32'(ov), 0);
        chk("rst_data", 32'(od), 0);
        chk("rst_tags", 32'({osof, oeol, oeof}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(alld), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_frames", 32'(fd), 0);

        // 1: single frame, downstream always ready
        nf = 8'd1; start = 1'b1; tick(); start = 1'b0;
        chk("t1_busy_sync", 32'(busy), 1);
        send_frame(1'b0);
        chk("t1_first_latency", 32'(first_vld), 1);
        chk("t1_first_sof", 32'(first_sof), 1);
        chk("t1_ovf_full_rate", 32'(ovf_hist[7]), 0);
        wait_both_done("t1");
        chk("t1_all_done", 32'(alld), 1);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_frames", 32'(fd), 1);
        check_q("t1", 1'b0, 16, 0);
        chk("t1_d4_write_on_full_pop", 32'(ovf4_hist[6]), 0);
        chk("t1_d4_drop", 32'(ovf4_hist[7]), 1);
        check_q("t1_d4", 1'b1, 14, 1);

        // 2: downstream ready toggles every cycle
        q.delete(); q4.delete();
        start = 1'b1; tick(); start = 1'b0;
        chk("t2_frames_cleared", 32'(fd), 0);
        chk("t2_ovf_cleared", 32'(ovf4), 0);
        tog = 1'b1;
        send_frame(1'b0);
        wait_both_done("t2");
        tog = 1'b0; rdy = 1'b1;
        check_q("t2", 1'b0, 16, 0);
        chk("t2_stall_stable", 32'(stall_viol), 0);
        chk("t2_frames", 32'(fd), 1);

        // 3: downstream stalled for the whole capture
        q.delete(); q4.delete();
        rdy = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        send_frame(1'b0);
        chk("t3_d4_ovf_before", 32'(ovf4_hist[3]), 0);
        chk("t3_d4_ovf_after5", 32'(ovf4_hist[4]), 1);
        chk("t3_exact_fill_no_ovf", 32'(ovf_hist[7]), 0);
        chk("t3_hold_data", 32'({ov, osof, od}), 32'h100 | 32'h200);
        start = 1'b1; tick(); start = 1'b0;
        chk("t3_start_ignored_busy", 32'(busy), 1);
        chk("t3_start_ignored_done", 32'(alld), 0);
        rdy = 1'b1;
        wait_both_done("t3");
        chk("t3_d4_ovf_sticky", 32'(ovf4), 1);
        check_q("t3", 1'b0, 16, 0);
        check_q("t3_d4", 1'b1, 8, 2);

        // 4: continuous mode, three frames
        q.delete(); q4.delete();
        nf = 8'd0; start = 1'b1; tick(); start = 1'b0;
        for (int f = 1; f <= 3; f++) begin
            int i;
            send_frame(1'b0);
            for (i = 0; i < 200 && !(fd == 8'(f) && fd4 == 8'(f)); i++) tick();
            chk($sformatf("t4_frame%0d_in_time", f), 32'(fd == 8'(f) && fd4 == 8'(f)), 1);
            chk($sformatf("t4_busy%0d", f), 32'(busy), 1);
            chk($sformatf("t4_not_done%0d", f), 32'(alld), 0);
        end
        chk("t4_frames", 32'(fd), 3);
        check_q("t4", 1'b0, 48, 0);

        // 5: reset mid-frame, flag high out of reset, stray words before an edge
        q.delete(); q4.delete();
        rdy = 1'b0;
        ff = 1'b1; tick(); ff = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vld = 1'b1; din = {8'(2*k+1), 8'(2*k)}; tick();
        end
        vld = 1'b0;
        chk("t5_pending", 32'(ov), 1);
        rst = 1'b1; ff = 1'b1; tick();
        chk("t5_rst_valid", 32'(ov), 0);
        chk("t5_rst_valid_d4", 32'(ov4), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_frames", 32'(fd), 0);
        rst = 1'b0; rdy = 1'b1; tick();
        chk("t5_no_partial", 32'(q.size()), 0);
        nf = 8'd1; start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vld = 1'b1; din = 16'hA5A5; tick();
        end
        vld = 1'b0;
        chk("t5_stray_ignored", 32'(ov), 0);
        chk("t5_stray_count", 32'(q.size()), 0);
        chk("t5_busy_sync", 32'(busy), 1);
        ff = 1'b0; tick();
        send_frame(1'b0);
        wait_both_done("t5");
        check_q("t5", 1'b0, 16, 0);

`ifdef SATURATION_COUNT_EN
        // 6: saturated pixel count
        start = 1'b1; tick(); start = 1'b0;
        send_frame(1'b1);
        wait_both_done("t6a");
        chk("t6_sat_after_eof", 32'(sat), 5);
        repeat (3) tick();
        chk("t6_sat_holds", 32'(sat), 5);
        start = 1'b1; tick(); start = 1'b0;
        send_frame(1'b0);
        wait_both_done("t6b");
        chk("t6_sat_cleared", 32'(sat), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
